// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants used by the fetch queue, its sub-modules and benches.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] RESET_PC = 32'h1c00_0000;
    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// ICache request/response bus between the fetch front end (master) and the instruction cache (slave).
interface inst_fetch_queue_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  icache_req;
    logic                  icache_ready;
    logic [ADDR_WIDTH-1:0] icache_addr;
    logic                  icache_rvalid;
    logic [DATA_WIDTH-1:0] icache_rdata;

    modport master (
        output icache_req,
        output icache_addr,
        input  icache_ready,
        input  icache_rvalid,
        input  icache_rdata
    );

    modport slave (
        input  icache_req,
        input  icache_addr,
        output icache_ready,
        output icache_rvalid,
        output icache_rdata
    );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction FIFO with a registered head entry; supports push, pop and clear in one cycle.
module inst_queue #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [PC_W-1:0]   push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              pop_i,
    output logic [PC_W-1:0]   head_pc_o,
    output logic [INST_W-1:0] head_inst_o,
    output logic              head_valid_o,
    output logic [PTR_W:0]    count_o
);

    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PC_W-1:0]   mem_pc_q   [DEPTH];
    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d;
    logic [INST_W-1:0] head_inst_q, head_inst_d;
    logic              head_valid_q, head_valid_d;
    logic [PTR_W:0]    count, count_after_pop;

    // The head is precomputed from pre-write storage, so a push into the slot
    // being vacated by a pop (full queue) cannot disturb the next head.
    always_comb begin
        count           = wr_ptr_q - rd_ptr_q;
        count_after_pop = pop_i ? count - PTR_ONE : count;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        head_pc_d       = '0;
        head_inst_d     = '0;
        head_valid_d    = 1'b0;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (push_i && count_after_pop == '0) begin
                head_pc_d    = push_pc_i;
                head_inst_d  = push_inst_i;
                head_valid_d = 1'b1;
            end else if (count_after_pop != '0) begin
                head_pc_d    = mem_pc_q[rd_ptr_d[PTR_W-1:0]];
                head_inst_d  = mem_inst_q[rd_ptr_d[PTR_W-1:0]];
                head_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            head_pc_q    <= '0;
            head_inst_q  <= '0;
            head_valid_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            head_pc_q    <= head_pc_d;
            head_inst_q  <= head_inst_d;
            head_valid_q <= head_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_pc_q[wr_ptr_q[PTR_W-1:0]]   <= push_pc_i;
            mem_inst_q[wr_ptr_q[PTR_W-1:0]] <= push_inst_i;
        end
    end

    assign head_pc_o    = head_pc_q;
    assign head_inst_o  = head_inst_q;
    assign head_valid_o = head_valid_q;
    assign count_o      = count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: credit-limited sequential ICache requests, in-order response queue, branch/flush redirect.
// Optional build macro FETCH_PERF_CNT_EN adds push and drop performance counters.
module inst_fetch_queue #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_flag_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_target_i,
    input  logic                  stall_i,
    inst_fetch_queue_if.master    icache,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_inst_o,
    output logic                  if_inst_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_drop_cnt_o
`endif
);

    import fetch_pkg::*;

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
    // Repeated redirects while the ICache is slow can stack stale responses beyond one queue's worth.
    localparam int unsigned DROP_W = CNT_W + 4;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]      q_count;
    logic [CNT_W:0]        credit_used;
    logic                  q_head_valid;
    logic                  redirect, issue, resp_keep, resp_drop, pop;
    logic [ADDR_WIDTH-1:0] redirect_target;

    assign redirect        = flush_i | branch_flag_i;
    assign redirect_target = flush_i ? flush_target_i : branch_target_i;
    assign credit_used     = {1'b0, q_count} + {1'b0, inflight_q};
    assign icache.icache_req  = !rst && !redirect && (credit_used < (CNT_W+1)'(QUEUE_DEPTH));
    assign icache.icache_addr = fetch_pc_q;
    assign issue     = icache.icache_req && icache.icache_ready;
    assign resp_drop = icache.icache_rvalid && (redirect || drop_cnt_q != '0);
    assign resp_keep = icache.icache_rvalid && !resp_drop;
    assign pop       = q_head_valid && !stall_i && !redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            inflight_d = '0;
            drop_cnt_d = drop_cnt_q + DROP_W'(inflight_q) - DROP_W'(icache.icache_rvalid);
        end else begin
            if (issue)     fetch_pc_d = fetch_pc_q + PC_STEP;
            if (resp_keep) resp_pc_d  = resp_pc_q + PC_STEP;
            inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(resp_keep);
            drop_cnt_d = drop_cnt_q - DROP_W'(resp_drop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    inst_queue #(
        .PC_W   (ADDR_WIDTH),
        .INST_W (DATA_WIDTH),
        .DEPTH  (QUEUE_DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (redirect),
        .push_i       (resp_keep),
        .push_pc_i    (resp_pc_q),
        .push_inst_i  (icache.icache_rdata),
        .pop_i        (pop),
        .head_pc_o    (if_pc_o),
        .head_inst_o  (if_inst_o),
        .head_valid_o (q_head_valid),
        .count_o      (q_count)
    );

    assign if_inst_valid_o = q_head_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d, perf_drop_cnt_q, perf_drop_cnt_d;

    // Drops include entries still sitting in the queue when a redirect clears it.
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + 32'(resp_keep);
        perf_drop_cnt_d  = perf_drop_cnt_q + 32'(resp_drop) + (redirect ? 32'(q_count) : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_q <= '0;
            perf_drop_cnt_q  <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_drop_cnt_q  <= perf_drop_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_cnt_q;
    assign perf_drop_cnt_o  = perf_drop_cnt_q;
`endif

    stray_resp_chk: assert property (@(posedge clk) disable iff (rst)
        icache.icache_rvalid |-> (inflight_q != '0 || drop_cnt_q != '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed fetch scenarios, ICache model, decoupled head monitor.
`timescale 1ns/1ps
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_flag, flush, stall;
    logic [31:0] branch_target, flush_target;
    logic [31:0] if_pc, if_inst;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_drop, snap_fetch, snap_drop;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) icache_bus ();

    inst_fetch_queue #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .RESET_PC    (32'h1c00_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .flush_i         (flush),
        .flush_target_i  (flush_target),
        .stall_i         (stall),
        .icache          (icache_bus),
        .if_pc_o         (if_pc),
        .if_inst_o       (if_inst),
        .if_inst_valid_o (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch),
        .perf_drop_cnt_o  (perf_drop)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    // ICache model: accepts on req&&ready, answers in order 'lat' cycles later.
    int          cyc = 0;
    int          lat = 1;
    int          n_accept = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            icache_bus.icache_rvalid = 1'b0;
            icache_bus.icache_rdata  = '0;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            icache_bus.icache_rvalid = 1'b1;
            icache_bus.icache_rdata  = inst_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            icache_bus.icache_rvalid = 1'b0;
            icache_bus.icache_rdata  = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst && icache_bus.icache_req && icache_bus.icache_ready) begin
            pend_addr.push_back(icache_bus.icache_addr);
            pend_due.push_back(cyc + lat);
            n_accept++;
        end
    end

    // Scoreboard monitor: the head must match the oldest expected entry; it is consumed when not stalled.
    fetch_entry_t exp_q[$];

    always @(negedge clk) begin
        if (!rst && if_valid && !(flush || branch_flag)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h, no entry expected", if_pc);
            end else begin
                check("head_pc", if_pc, exp_q[0].pc);
                check("head_inst", if_inst, exp_q[0].inst);
                if (!stall) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_addr.size() != 0) && n < 60) begin
            step();
            n++;
        end
        check("drain_in_time", 32'(n < 60), 32'd1);
        repeat (3) step();
        @(negedge clk);
        check("idle_no_valid", 32'(if_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        rst = 1'b1;
        branch_flag = 1'b0; branch_target = '0;
        flush = 1'b0; flush_target = '0; stall = 1'b0;
        icache_bus.icache_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_inst", if_inst, 32'd0);
        check("rst_req", 32'(icache_bus.icache_req), 32'd0);
        check("rst_addr", icache_bus.icache_addr, 32'h1c00_0000);

        // S1: sequential fetch after reset, one response per accept
        step(); rst = 1'b0; icache_bus.icache_ready = 1'b1;
        for (int i = 0; i < 6; i++) expect_pc(32'h1c00_0000 + 32'(4*i));
        @(negedge clk);
        check("s1_req_c0", 32'(icache_bus.icache_req), 32'd1);
        check("s1_addr_c0", icache_bus.icache_addr, 32'h1c00_0000);
        step();
        step(); @(negedge clk);
        check("s1_valid_c2", 32'(if_valid), 32'd1);
        check("s1_pc_c2", if_pc, 32'h1c00_0000);
        step(); @(negedge clk);
        check("s1_pc_c3", if_pc, 32'h1c00_0004);
        step(); @(negedge clk);
        check("s1_pc_c4", if_pc, 32'h1c00_0008);
        step();
        step(); icache_bus.icache_ready = 1'b0;
        wait_drain();

        // S2: stall held 10 cycles, credits cap requests at 4
        step(); stall = 1'b1; icache_bus.icache_ready = 1'b1; a0 = n_accept;
        for (int i = 0; i < 4; i++) expect_pc(32'h1c00_0018 + 32'(4*i));
        for (int c = 1; c <= 9; c++) begin
            step(); @(negedge clk);
            if (c >= 4) check("s2_req_off", 32'(icache_bus.icache_req), 32'd0);
        end
        check("s2_accepts", 32'(n_accept - a0), 32'd4);
        check("s2_head_hold", if_pc, 32'h1c00_0018);
        step(); stall = 1'b0; icache_bus.icache_ready = 1'b0;
        wait_drain();

        // S6: push and pop in the same cycle at the credit limit
        step(); stall = 1'b1; icache_bus.icache_ready = 1'b1; a0 = n_accept;
        for (int i = 0; i < 5; i++) expect_pc(32'h1c00_0028 + 32'(4*i));
        repeat (5) step();
        step(); stall = 1'b0;
        step(); stall = 1'b1;
        step(); stall = 1'b0;
        @(negedge clk);
        check("s6_rvalid_c8", 32'(icache_bus.icache_rvalid), 32'd1);
        check("s6_req_c8", 32'(icache_bus.icache_req), 32'd0);
        check("s6_pc_c8", if_pc, 32'h1c00_002c);
        step(); stall = 1'b1; icache_bus.icache_ready = 1'b0;
        @(negedge clk);
        check("s6_pc_c9", if_pc, 32'h1c00_0030);
        step(); step();
        step(); stall = 1'b0;
        wait_drain();
        check("s6_accepts", 32'(n_accept - a0), 32'd5);

        // S3: branch with two requests in flight
        lat = 3;
`ifdef FETCH_PERF_CNT_EN
        snap_drop = perf_drop;
`endif
        step(); icache_bus.icache_ready = 1'b1;
        step();
        step(); icache_bus.icache_ready = 1'b0;
        branch_flag = 1'b1; branch_target = 32'h1c00_0100;
        expect_pc(32'h1c00_0100); expect_pc(32'h1c00_0104);
        @(negedge clk);
        check("s3_req_redirect", 32'(icache_bus.icache_req), 32'd0);
        step(); branch_flag = 1'b0; icache_bus.icache_ready = 1'b1;
        @(negedge clk);
        check("s3_addr_target", icache_bus.icache_addr, 32'h1c00_0100);
        step();
        step(); icache_bus.icache_ready = 1'b0;
        wait_drain();
`ifdef FETCH_PERF_CNT_EN
        check("s3_perf_drop", perf_drop - snap_drop, 32'd2);
`endif
        lat = 1;

        // S4: flush and branch together, flush target wins
        step(); flush = 1'b1; flush_target = 32'h1c00_1000;
        branch_flag = 1'b1; branch_target = 32'h1c00_0200;
        expect_pc(32'h1c00_1000); expect_pc(32'h1c00_1004);
        @(negedge clk);
        check("s4_req_redirect", 32'(icache_bus.icache_req), 32'd0);
        step(); flush = 1'b0; branch_flag = 1'b0; icache_bus.icache_ready = 1'b1;
        @(negedge clk);
        check("s4_addr_flush", icache_bus.icache_addr, 32'h1c00_1000);
        step();
        step(); icache_bus.icache_ready = 1'b0;
        wait_drain();

        // S5: PC wrap at the top of the address space
        step(); branch_flag = 1'b1; branch_target = 32'hFFFF_FFF8;
        expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0000_0000);
        step(); branch_flag = 1'b0; icache_bus.icache_ready = 1'b1;
        step(); step();
        step(); icache_bus.icache_ready = 1'b0;
        @(negedge clk);
        check("s5_addr_wrap", icache_bus.icache_addr, 32'h0000_0004);
        wait_drain();

        // S7: flush while the queue is full
`ifdef FETCH_PERF_CNT_EN
        snap_drop = perf_drop; snap_fetch = perf_fetch;
`endif
        step(); stall = 1'b1; icache_bus.icache_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(32'h0000_0004 + 32'(4*i));
        repeat (5) step();
        step(); icache_bus.icache_ready = 1'b0; flush = 1'b1; flush_target = 32'h1c00_2000;
        exp_q.delete();
        expect_pc(32'h1c00_2000);
        step(); flush = 1'b0; stall = 1'b0; icache_bus.icache_ready = 1'b1;
        @(negedge clk);
        check("s7_cleared", 32'(if_valid), 32'd0);
        step(); icache_bus.icache_ready = 1'b0;
        wait_drain();
`ifdef FETCH_PERF_CNT_EN
        check("s7_perf_drop", perf_drop - snap_drop, 32'd4);
        check("s7_perf_fetch", perf_fetch - snap_fetch, 32'd5);
`endif

        // S8: reset asserted mid-stream
        step(); icache_bus.icache_ready = 1'b1;
        expect_pc(32'h1c00_2004); expect_pc(32'h1c00_2008); expect_pc(32'h1c00_200c);
        step(); step(); step();
        step(); rst = 1'b1; exp_q.delete();
        @(negedge clk);
        check("s8_rst_valid", 32'(if_valid), 32'd0);
        check("s8_rst_pc", if_pc, 32'd0);
        check("s8_rst_req", 32'(icache_bus.icache_req), 32'd0);
        check("s8_rst_addr", icache_bus.icache_addr, 32'h1c00_0000);
        step(); rst = 1'b0; icache_bus.icache_ready = 1'b0;
        step(); @(negedge clk);
        check("s8_post_valid", 32'(if_valid), 32'd0);
        check("s8_post_addr", icache_bus.icache_addr, 32'h1c00_0000);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
